// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: NUM_PORTS x WIDTH ports with DDR/PORT/PIN, input synchroniser and pull-up indication.
// Optional pin-change interrupt logic is built when GPIO_PIN_CHANGE_IRQ_EN is defined.
module gpio_bank #(
    parameter int NUM_PORTS   = 4,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic [WIDTH-1:0]           write_data,
    input  logic [NUM_PORTS-1:0]       ddr_we,
    input  logic [NUM_PORTS-1:0]       port_we,
    input  logic [NUM_PORTS-1:0]       pin_we,
    input  logic [NUM_PORTS-1:0]       pcmsk_we,
    input  logic                       pcicr_we,
    input  logic                       pcifr_we,
    input  logic                       pud,
    input  logic [NUM_PORTS*WIDTH-1:0] pins_in,
    output logic [NUM_PORTS*WIDTH-1:0] ddr_out,
    output logic [NUM_PORTS*WIDTH-1:0] port_out,
    output logic [NUM_PORTS*WIDTH-1:0] pin_out,
    output logic [NUM_PORTS*WIDTH-1:0] pullup_out,
    output logic [NUM_PORTS*WIDTH-1:0] pcmsk_out,
    output logic [WIDTH-1:0]           pcicr_out,
    output logic [WIDTH-1:0]           pcifr_out,
    output logic                       irq
);

    localparam int TW = NUM_PORTS * WIDTH;

    logic [TW-1:0]                   ddr_r;
    logic [TW-1:0]                   port_r;
    logic [TW-1:0]                   ddr_nxt_s;
    logic [TW-1:0]                   port_nxt_s;
    logic [SYNC_STAGES-1:0][TW-1:0]  sync_r;

    // Next DDR value from per-port write enables
    always_comb begin
        ddr_nxt_s = ddr_r;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (ddr_we[p]) begin
                ddr_nxt_s[p*WIDTH +: WIDTH] = write_data;
            end else begin
                ddr_nxt_s[p*WIDTH +: WIDTH] = ddr_r[p*WIDTH +: WIDTH];
            end
        end
    end

    // Next PORT value: a direct write overrides a same-cycle toggle
    always_comb begin
        port_nxt_s = port_r;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_we[p]) begin
                port_nxt_s[p*WIDTH +: WIDTH] = write_data;
            end else if (pin_we[p]) begin
                port_nxt_s[p*WIDTH +: WIDTH] = port_r[p*WIDTH +: WIDTH] ^ write_data;
            end else begin
                port_nxt_s[p*WIDTH +: WIDTH] = port_r[p*WIDTH +: WIDTH];
            end
        end
    end

    // DDR and PORT registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ddr_r  <= {TW{1'b0}};
            port_r <= {TW{1'b0}};
        end else begin
            ddr_r  <= ddr_nxt_s;
            port_r <= port_nxt_s;
        end
    end

    // Pad synchroniser; the last stage is the PIN register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_r <= {(SYNC_STAGES*TW){1'b0}};
        end else begin
            sync_r[0] <= pins_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    assign ddr_out    = ddr_r;
    assign port_out   = port_r;
    assign pin_out    = sync_r[SYNC_STAGES-1];
    assign pullup_out = ~ddr_r & port_r & {TW{~pud}};

`ifdef GPIO_PIN_CHANGE_IRQ_EN
    logic [TW-1:0]        pcmsk_r;
    logic [TW-1:0]        prev_r;
    logic [NUM_PORTS-1:0] pcie_r;
    logic [NUM_PORTS-1:0] pcif_r;
    logic [TW-1:0]        pcmsk_nxt_s;
    logic [TW-1:0]        chg_bits_s;
    logic [NUM_PORTS-1:0] chg_s;
    logic [NUM_PORTS-1:0] pcif_clr_s;
    logic [WIDTH-1:0]     pcicr_s;
    logic [WIDTH-1:0]     pcifr_s;

    // Mask writes and per-port change detection on the synchronised pins
    always_comb begin
        pcmsk_nxt_s = pcmsk_r;
        chg_bits_s  = (sync_r[SYNC_STAGES-1] ^ prev_r) & pcmsk_r;
        chg_s       = {NUM_PORTS{1'b0}};
        for (int p = 0; p < NUM_PORTS; p++) begin
            chg_s[p] = |chg_bits_s[p*WIDTH +: WIDTH];
            if (pcmsk_we[p]) begin
                pcmsk_nxt_s[p*WIDTH +: WIDTH] = write_data;
            end else begin
                pcmsk_nxt_s[p*WIDTH +: WIDTH] = pcmsk_r[p*WIDTH +: WIDTH];
            end
        end
        if (pcifr_we) begin
            pcif_clr_s = write_data[NUM_PORTS-1:0];
        end else begin
            pcif_clr_s = {NUM_PORTS{1'b0}};
        end
    end

    // Pin-change state; a new change wins over a same-cycle flag clear
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pcmsk_r <= {TW{1'b0}};
            prev_r  <= {TW{1'b0}};
            pcie_r  <= {NUM_PORTS{1'b0}};
            pcif_r  <= {NUM_PORTS{1'b0}};
        end else begin
            pcmsk_r <= pcmsk_nxt_s;
            prev_r  <= sync_r[SYNC_STAGES-1];
            if (pcicr_we) begin
                pcie_r <= write_data[NUM_PORTS-1:0];
            end else begin
                pcie_r <= pcie_r;
            end
            pcif_r <= (pcif_r & ~pcif_clr_s) | chg_s;
        end
    end

    // Zero-extend enable and flag registers onto the WIDTH-wide read bus
    always_comb begin
        pcicr_s = {WIDTH{1'b0}};
        pcifr_s = {WIDTH{1'b0}};
        pcicr_s[NUM_PORTS-1:0] = pcie_r;
        pcifr_s[NUM_PORTS-1:0] = pcif_r;
    end

    assign pcmsk_out = pcmsk_r;
    assign pcicr_out = pcicr_s;
    assign pcifr_out = pcifr_s;
    assign irq       = |(pcif_r & pcie_r);
`else
    logic unused_s;

    assign unused_s  = ^{pcmsk_we, pcicr_we, pcifr_we};
    assign pcmsk_out = {TW{1'b0}};
    assign pcicr_out = {WIDTH{1'b0}};
    assign pcifr_out = {WIDTH{1'b0}};
    assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank (default parameters); pin-change expectations
// follow whether GPIO_PIN_CHANGE_IRQ_EN is defined.
module tb_gpio_bank;

    localparam int NP = 4;
    localparam int W  = 8;
    localparam int TW = NP * W;

`ifdef GPIO_PIN_CHANGE_IRQ_EN
    localparam bit PC = 1'b1;
`else
    localparam bit PC = 1'b0;
`endif

    logic          clk;
    logic          clr_n;
    logic [W-1:0]  write_data;
    logic [NP-1:0] ddr_we, port_we, pin_we, pcmsk_we;
    logic          pcicr_we, pcifr_we, pud;
    logic [TW-1:0] pins_in;
    logic [TW-1:0] ddr_out, port_out, pin_out, pullup_out, pcmsk_out;
    logic [W-1:0]  pcicr_out, pcifr_out;
    logic          irq;

    int checks = 0;
    int errors = 0;

    gpio_bank #(.NUM_PORTS(NP), .WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .clr_n(clr_n), .write_data(write_data),
        .ddr_we(ddr_we), .port_we(port_we), .pin_we(pin_we), .pcmsk_we(pcmsk_we),
        .pcicr_we(pcicr_we), .pcifr_we(pcifr_we), .pud(pud), .pins_in(pins_in),
        .ddr_out(ddr_out), .port_out(port_out), .pin_out(pin_out), .pullup_out(pullup_out),
        .pcmsk_out(pcmsk_out), .pcicr_out(pcicr_out), .pcifr_out(pcifr_out), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clr_n = 1'b0; write_data = 8'h00; ddr_we = 4'h0; port_we = 4'h0; pin_we = 4'h0;
        pcmsk_we = 4'h0; pcicr_we = 1'b0; pcifr_we = 1'b0; pud = 1'b0;
        pins_in = 32'hFFFF_FFFF;
        tick(2);
        // 1: reset state with pads high
        check("rst_ddr", ddr_out, 32'h0);
        check("rst_port", port_out, 32'h0);
        check("rst_pin", pin_out, 32'h0);
        check("rst_pullup", pullup_out, 32'h0);
        check("rst_pcmsk", pcmsk_out, 32'h0);
        check("rst_pcicr", {24'h0, pcicr_out}, 32'h0);
        check("rst_pcifr", {24'h0, pcifr_out}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        clr_n = 1'b1;
        tick(1);
        check("rel_pin_e1", pin_out, 32'h0);
        tick(1);
        check("rel_pin_e2", pin_out, 32'hFFFF_FFFF);
        check("rel_irq", {31'h0, irq}, 32'h0);
        check("rel_pcifr", {24'h0, pcifr_out}, 32'h0);

        // 2: DDR / PORT / pull-up
        ddr_we = 4'h2; write_data = 8'hF0;
        tick(1);
        ddr_we = 4'h0;
        check("ddr1", ddr_out, 32'h0000_F000);
        port_we = 4'h2; write_data = 8'hA5;
        tick(1);
        port_we = 4'h0;
        check("port1", port_out, 32'h0000_A500);
        check("pullup1", pullup_out, 32'h0000_0500);
        pud = 1'b1;
        #1;
        check("pullup_pud", pullup_out, 32'h0);
        pud = 1'b0;

        // 3: toggle and write-over-toggle priority
        port_we = 4'h1; write_data = 8'h0F;
        tick(1);
        port_we = 4'h0; pin_we = 4'h1; write_data = 8'hFF;
        tick(1);
        pin_we = 4'h0;
        check("toggle0", port_out, 32'h0000_A5F0);
        port_we = 4'h1; pin_we = 4'h1; write_data = 8'h33;
        tick(1);
        port_we = 4'h0; pin_we = 4'h0;
        check("port_over_pin", port_out, 32'h0000_A533);
        pin_we = 4'h2; write_data = 8'h0F;
        tick(1);
        pin_we = 4'h0;
        check("toggle1", port_out, 32'h0000_AA33);

        // 4: synchroniser latency
        pins_in = 32'h0;
        tick(3);
        check("pins_low", pin_out, 32'h0);
        pins_in = 32'h0000_0080;
        tick(1);
        check("sync_e1", pin_out, 32'h0);
        tick(1);
        check("sync_e2", pin_out, 32'h0000_0080);

        // 5: pin-change flag and irq on port 2 bit 0
        pcmsk_we = 4'h4; write_data = 8'h01;
        tick(1);
        pcmsk_we = 4'h0;
        check("pcmsk", pcmsk_out, PC ? 32'h0001_0000 : 32'h0);
        pcicr_we = 1'b1; write_data = 8'h04;
        tick(1);
        pcicr_we = 1'b0;
        check("pcicr", {24'h0, pcicr_out}, PC ? 32'h4 : 32'h0);
        check("no_flag_from_mask", {24'h0, pcifr_out}, 32'h0);
        pins_in = 32'h0001_0080;
        tick(2);
        check("pin16_seen", pin_out, 32'h0001_0080);
        check("flag_not_yet", {24'h0, pcifr_out}, 32'h0);
        tick(1);
        check("flag_set", {24'h0, pcifr_out}, PC ? 32'h4 : 32'h0);
        check("irq_set", {31'h0, irq}, PC ? 32'h1 : 32'h0);
        pcifr_we = 1'b1; write_data = 8'h04;
        tick(1);
        pcifr_we = 1'b0;
        check("flag_clr", {24'h0, pcifr_out}, 32'h0);
        check("irq_clr", {31'h0, irq}, 32'h0);
        pins_in = 32'h0000_0080;
        tick(2);
        pcifr_we = 1'b1; write_data = 8'h04;
        tick(1);
        pcifr_we = 1'b0;
        check("set_beats_clr", {24'h0, pcifr_out}, PC ? 32'h4 : 32'h0);
        pcifr_we = 1'b1; write_data = 8'h04;
        tick(1);
        pcifr_we = 1'b0;
        check("flag_clr2", {24'h0, pcifr_out}, 32'h0);

        // 6: unmasked edge, and masked edge with irq disabled
        pins_in = 32'h0002_0080;
        tick(3);
        check("unmasked_edge", {24'h0, pcifr_out}, 32'h0);
        pcicr_we = 1'b1; write_data = 8'h00;
        tick(1);
        pcicr_we = 1'b0;
        check("pcie_off", {24'h0, pcicr_out}, 32'h0);
        pins_in = 32'h0003_0080;
        tick(3);
        check("flag_no_pcie", {24'h0, pcifr_out}, PC ? 32'h4 : 32'h0);
        check("irq_no_pcie", {31'h0, irq}, 32'h0);

        // asynchronous reset mid-operation, then clean restart
        clr_n = 1'b0;
        #1;
        check("mid_rst_ddr", ddr_out, 32'h0);
        check("mid_rst_port", port_out, 32'h0);
        check("mid_rst_pin", pin_out, 32'h0);
        check("mid_rst_pcmsk", pcmsk_out, 32'h0);
        check("mid_rst_pcifr", {24'h0, pcifr_out}, 32'h0);
        pins_in = 32'h0;
        tick(2);
        clr_n = 1'b1;
        tick(3);
        check("post_rst_pcifr", {24'h0, pcifr_out}, 32'h0);
        check("post_rst_pin", pin_out, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
